// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: source selects, flag bit
// positions inside {N,Z,C,V}, and flag-group write-enable bit positions.
package wb_pkg;

  // Write-back source select (in_S_MXRB)
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] SEL_FLG = 2'b11;

  // Bit positions inside the 4-bit {N,Z,C,V} flags word
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Bit positions inside in_W_RF
  localparam int WRF_NZ = 2;
  localparam int WRF_C  = 1;
  localparam int WRF_V  = 0;

endpackage

// File: rtl/regfile16x32.sv
// Architectural register file: one synchronous write port, two
// combinational read ports, every register cleared by the async reset.
// No register is hard-wired to zero.
module regfile16x32 #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  // Register array: clear all entries on reset, otherwise single write port
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Raw reads of committed state; bypassing is the caller's concern
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: picks the write-back value, commits it to the register
// file, updates NZCV, counts retired instructions and feeds forwarding info
// and bypassed register reads back to decode/execute.
//
// Slot semantics: in_valid=1 marks a real instruction that retires on the
// next rising CLK; in_valid=0 is a bubble that touches no state. There is no
// back-pressure, so the stage has no ready signal.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     in_valid,
  input  logic [$clog2(NREGS)-1:0] in_WC,
  input  logic [DATA_W-1:0]        in_PC,
  input  logic [DATA_W-1:0]        in_PR,
  input  logic [DATA_W-1:0]        in_alu_res,
  input  logic [3:0]               in_flags,
  input  logic [1:0]               in_S_MXRB,
  input  logic                     in_W_RB,
  input  logic [2:0]               in_W_RF,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic                     wb_we,
  output logic [$clog2(NREGS)-1:0] wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [3:0]               flags_q,
  output logic [31:0]              retire_count
);

  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [3:0]        flags_r;
  logic [31:0]       retire_q;

  // Write-back source mux and forwarding outputs
  always_comb begin
    wb_data = in_alu_res;
    case (in_S_MXRB)
      SEL_ALU: wb_data = in_alu_res;
      SEL_MEM: wb_data = in_PR;
      SEL_PC:  wb_data = in_PC;
      SEL_FLG: wb_data = {{(DATA_W-4){1'b0}}, in_flags};
      default: wb_data = in_alu_res;
    endcase
    wb_we   = in_valid & in_W_RB;
    wb_addr = in_WC;
  end

  regfile16x32 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .CLK     (CLK),
    .RESET   (RESET),
    .we      (wb_we),
    .waddr   (in_WC),
    .wdata   (wb_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  // Write-through bypass so decode sees this cycle's write with no gap
  always_comb begin
    rd_data_a = (wb_we && (rd_addr_a == in_WC)) ? wb_data : rf_rdata_a;
    rd_data_b = (wb_we && (rd_addr_b == in_WC)) ? wb_data : rf_rdata_b;
  end

  // Flags register: per-group enables, only for valid instructions
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flags_r <= 4'b0000;
    end else if (in_valid) begin
      if (in_W_RF[WRF_NZ]) begin
        flags_r[FLG_N] <= in_flags[FLG_N];
        flags_r[FLG_Z] <= in_flags[FLG_Z];
      end
      if (in_W_RF[WRF_C]) begin
        flags_r[FLG_C] <= in_flags[FLG_C];
      end
      if (in_W_RF[WRF_V]) begin
        flags_r[FLG_V] <= in_flags[FLG_V];
      end
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      retire_q <= 32'd0;
    end else if (in_valid) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign flags_q      = flags_r;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed expectations for reset,
// select paths, bypass, bubbles, partial flag writes, counter wrap and
// reset arriving in the middle of a write.
module tb_wb_stage;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic [3:0]  in_WC;
  logic [31:0] in_PC;
  logic [31:0] in_PR;
  logic [31:0] in_alu_res;
  logic [3:0]  in_flags;
  logic [1:0]  in_S_MXRB;
  logic        in_W_RB;
  logic [2:0]  in_W_RF;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  flags_q;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .in_valid     (in_valid),
    .in_WC        (in_WC),
    .in_PC        (in_PC),
    .in_PR        (in_PR),
    .in_alu_res   (in_alu_res),
    .in_flags     (in_flags),
    .in_S_MXRB    (in_S_MXRB),
    .in_W_RB      (in_W_RB),
    .in_W_RF      (in_W_RF),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flags_q      (flags_q),
    .retire_count (retire_count)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [3:0] wc, input logic [1:0] sel,
                       input logic [31:0] pc, input logic [31:0] pr, input logic [31:0] alu,
                       input logic [3:0] fl, input logic wrb, input logic [2:0] wrf);
    in_valid   = v;
    in_WC      = wc;
    in_S_MXRB  = sel;
    in_PC      = pc;
    in_PR      = pr;
    in_alu_res = alu;
    in_flags   = fl;
    in_W_RB    = wrb;
    in_W_RF    = wrf;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'b000);
  endtask

  // present a slot at negedge, let it settle, then take one rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    idle();
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd0;
    #12;
    check("rst_rd_a", rd_data_a, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);

    @(negedge CLK);
    RESET = 1'b1;

    // ALU write to R5, with same-cycle bypass on port a
    @(negedge CLK);
    drive(1'b1, 4'd5, 2'b00, 32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 4'd0, 1'b1, 3'b000);
    rd_addr_a = 4'd5;
    rd_addr_b = 4'd4;
    #1;
    check("r5_wb_we", {31'd0, wb_we}, 32'd1);
    check("r5_wb_addr", {28'd0, wb_addr}, 32'd5);
    check("r5_wb_data", wb_data, 32'hDEAD_BEEF);
    check("r5_bypass_a", rd_data_a, 32'hDEAD_BEEF);
    check("r4_no_bypass_b", rd_data_b, 32'd0);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("r5_commit", rd_data_a, 32'hDEAD_BEEF);
    check("retire_1", retire_count, 32'd1);

    // memory-data write to R3, bypass on both ports
    drive(1'b1, 4'd3, 2'b01, 32'h1111_1111, 32'h1234_5678, 32'hAAAA_AAAA, 4'd0, 1'b1, 3'b000);
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd3;
    #1;
    check("r3_bypass_a", rd_data_a, 32'h1234_5678);
    check("r3_bypass_b", rd_data_b, 32'h1234_5678);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("r3_commit", rd_data_b, 32'h1234_5678);
    check("retire_2", retire_count, 32'd2);

    // PC (link) write to R15
    drive(1'b1, 4'd15, 2'b10, 32'h0000_0040, 32'h5555_5555, 32'h6666_6666, 4'd0, 1'b1, 3'b000);
    step();
    @(negedge CLK);
    idle();
    rd_addr_a = 4'd15;
    #1;
    check("r15_commit", rd_data_a, 32'h0000_0040);
    check("retire_3", retire_count, 32'd3);

    // bubble aimed at R15: forwarding follows inputs but nothing commits
    drive(1'b0, 4'd15, 2'b00, 32'd0, 32'd0, 32'hFFFF_0000, 4'b1111, 1'b1, 3'b111);
    #1;
    check("bub_wb_we", {31'd0, wb_we}, 32'd0);
    check("bub_wb_addr", {28'd0, wb_addr}, 32'd15);
    check("bub_wb_data", wb_data, 32'hFFFF_0000);
    check("bub_no_bypass", rd_data_a, 32'h0000_0040);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("bub_r15_kept", rd_data_a, 32'h0000_0040);
    check("bub_retire", retire_count, 32'd3);
    check("bub_flags", {28'd0, flags_q}, 32'd0);

    // flags-as-data write to R1, no flag update
    drive(1'b1, 4'd1, 2'b11, 32'd0, 32'd0, 32'd0, 4'b1010, 1'b1, 3'b000);
    #1;
    check("flg_wb_data", wb_data, 32'h0000_000A);
    step();
    @(negedge CLK);
    idle();
    rd_addr_a = 4'd1;
    #1;
    check("r1_commit", rd_data_a, 32'h0000_000A);
    check("flg_sel_flags", {28'd0, flags_q}, 32'd0);
    check("retire_4", retire_count, 32'd4);

    // partial flag update: C only, no register write to R5
    drive(1'b1, 4'd5, 2'b00, 32'd0, 32'd0, 32'd0, 4'b1111, 1'b0, 3'b010);
    step();
    @(negedge CLK);
    idle();
    rd_addr_a = 4'd5;
    #1;
    check("flags_c", {28'd0, flags_q}, 32'h2);
    check("r5_no_wrb", rd_data_a, 32'hDEAD_BEEF);
    check("retire_5", retire_count, 32'd5);

    // N,Z update; flags are not bypassed before the edge
    drive(1'b1, 4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 4'b0100, 1'b0, 3'b100);
    #1;
    check("flags_no_bypass", {28'd0, flags_q}, 32'h2);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("flags_nz", {28'd0, flags_q}, 32'h6);

    // V update
    drive(1'b1, 4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 4'b0001, 1'b0, 3'b001);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("flags_v", {28'd0, flags_q}, 32'h7);
    check("retire_7", retire_count, 32'd7);

    // bubble with all flag enables set changes nothing
    drive(1'b0, 4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 4'b1000, 1'b0, 3'b111);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("bub_flags_kept", {28'd0, flags_q}, 32'h7);
    check("bub_retire_7", retire_count, 32'd7);

    // counter wrap: preload all-ones, then one valid cycle
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    check("retire_preload", retire_count, 32'hFFFF_FFFF);
    drive(1'b1, 4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'b000);
    step();
    @(negedge CLK);
    idle();
    #1;
    check("retire_wrap", retire_count, 32'd0);

    // reset asserted while a valid write to R7 sits at the edge
    drive(1'b1, 4'd7, 2'b00, 32'd0, 32'd0, 32'h7777_7777, 4'b1111, 1'b1, 3'b111);
    #3;
    RESET = 1'b0;
    step();
    idle();
    rd_addr_a = 4'd7;
    rd_addr_b = 4'd5;
    #1;
    check("rstmid_r7", rd_data_a, 32'd0);
    check("rstmid_r5", rd_data_b, 32'd0);
    check("rstmid_flags", {28'd0, flags_q}, 32'd0);
    check("rstmid_retire", retire_count, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // first valid write after release is counted as 1
    @(negedge CLK);
    drive(1'b1, 4'd2, 2'b00, 32'd0, 32'd0, 32'h0000_0022, 4'd0, 1'b1, 3'b000);
    step();
    @(negedge CLK);
    idle();
    rd_addr_a = 4'd2;
    #1;
    check("post_rst_r2", rd_data_a, 32'h0000_0022);
    check("post_rst_retire", retire_count, 32'd1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the pipeline. Consumes the EX/MEM→WB pipeline register outputs and selects the write-back value. It commits that value to the 16×32 architectural register file and updates the NZCV flags register. The stage also returns forwarding information and register-file read data to the decode/execute side, and keeps a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 32, datapath width.
- NREGS, 16, register count; address width is 4.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  WB slot holds a real instruction (0 = bubble).
- in_WC  in  4  destination register.
- in_PC  in  32  PC of the instruction (link value).
- in_PR  in  32  memory read data.
- in_alu_res  in  32  ALU result.
- in_flags  in  4  ALU flags {N,Z,C,V} (bit 3..0).
- in_S_MXRB  in  2  write-back source select.
- in_W_RB  in  1  register-file write request.
- in_W_RF  in  3  flag-group write enables.
- rd_addr_a, rd_addr_b  in  4 each  decode read addresses.
- rd_data_a, rd_data_b  out  32 each  read data, with write-through bypass.
- wb_we  out  1  forwarding: in_valid & in_W_RB.
- wb_addr  out  4  forwarding: in_WC.
- wb_data  out  32  forwarding: selected write-back value.
- flags_q  out  4  committed {N,Z,C,V}.
- retire_count  out  32  number of valid instructions retired.

## Operation
- Source select on in_S_MXRB:
  - 00: in_alu_res.
  - 01: in_PR.
  - 10: in_PC.
  - 11: {28'b0, in_flags}.
- wb_data is combinational from the select.
- Register write: when in_valid=1 and in_W_RB=1, reg[in_WC] ← wb_data at the rising edge. All 16 registers are writable; there is no hard-wired zero.
- Flag write is gated by in_valid:
  - in_W_RF[2] updates N and Z.
  - in_W_RF[1] updates C.
  - in_W_RF[0] updates V.
  - Unselected flag bits hold their value. The flag write is independent of in_W_RB.
- Retire counter: increments by 1 on each edge with in_valid=1 and wraps from 32'hFFFF_FFFF to 0.
- Bubble (in_valid=0):
  - no register, flag, or counter change;
  - wb_we=0;
  - wb_addr and wb_data still follow their inputs.
- Read ports are combinational, with bypass applied per port. If wb_we=1 and rd_addr_x==in_WC, rd_data_x=wb_data; otherwise rd_data_x=reg[rd_addr_x].

## Timing
- Write latency: 1 cycle to architectural state. The same-cycle value is visible through the bypass, so there is 0 effective read-after-write gap.
- Flags: flags_q reflects the update one cycle after the edge. flags_q is not bypassed.
- Reset (RESET=0, asynchronous):
  - all 16 registers = 0;
  - flags_q = 4'b0000;
  - retire_count = 0.
  - Reset is held while RESET=0. Release takes effect on the first rising CLK with RESET=1.
- Reset asserted mid-operation wins over any write on the same edge. The in-flight instruction is lost and is not counted.
- Combinational outputs (rd_data_*, wb_*) follow their inputs during reset. rd_data_* returns 0 from the cleared registers unless bypassed.
- There are no X-dependent outputs, provided the inputs are known.

## Structure
- Package wb_pkg holds:
  - select encodings SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_PC=2'b10, SEL_FLG=2'b11;
  - flag indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0;
  - W_RF bit indices WRF_NZ=2, WRF_C=1, WRF_V=0.
- Sub-module regfile16x32 contains:
  - the register array with asynchronous active-low reset;
  - one write port;
  - two combinational read ports.
- Bypass muxes, flags register and retire counter live in wb_stage.

## Test plan
- Reset then write: release reset, write in_WC=5, S_MXRB=00, alu_res=32'hDEAD_BEEF, W_RB=1. Expected next cycle: rd_addr_a=5 → 32'hDEAD_BEEF, retire_count=1.
- Bypass, select and bubble:
  - Same cycle as a write to R3 with S_MXRB=01, PR=32'h1234_5678: rd_addr_a=rd_addr_b=3 both return 32'h1234_5678 before the edge.
  - S_MXRB=10, PC=32'h0000_0040, W_RB=1 to R15: R15 = 32'h40.
  - Repeat the R15 write with in_valid=0: R15 unchanged, wb_we=0, retire_count unchanged.
- Partial flags: flags_q=4'b0000, in_flags=4'b1111, W_RF=3'b010 → flags_q=4'b0010. Then W_RF=3'b100 with in_flags=4'b0100 → flags_q=4'b0110.
- Counter wrap: preload retire_count to 32'hFFFF_FFFF with 2^32−1 valid cycles, or via a force. One more valid cycle → 0.
- Reset mid-write: assert RESET=0 while a valid write to R7 is presented at the edge. Expected: R7=0, flags_q=0, retire_count=0. After release, the first valid write is counted as 1.
